pcm_mem_arbiter: RTL

//  Shares the single PCM sample-memory read port between the ADPCM-A reader and the ADPCM-B

---
 rtl/pcm_mem_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/pcm_mem_arbiter.sv
// Round-robin arbiter (optional B priority) sharing one PCM read port between ADPCM-A and ADPCM-B.
// Grant to mem_valid takes 1 cycle. A requester waits until granted, and its ready pulse follows mem_ready combinationally.
module pcm_mem_arbiter #(
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 8,
  parameter int STAT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  a_valid,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  output logic                  a_ready,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_valid,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  output logic                  b_ready,
  output logic [DATA_WIDTH-1:0] b_rdata,
  input  logic                  b_priority,
  output logic                  mem_valid,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  stat_clear,
  output logic [STAT_WIDTH-1:0] a_grant_count,
  output logic [STAT_WIDTH-1:0] b_grant_count,
  output logic [STAT_WIDTH-1:0] max_wait
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY_A = 2'd1, BUSY_B = 2'd2} state_t;

  localparam logic [STAT_WIDTH-1:0] STAT_MAX = '1;

  state_t                state;
  logic                  last_grant_b;
  logic                  grant_a;
  logic                  grant_b;
  logic                  done_a;
  logic                  done_b;
  logic [STAT_WIDTH-1:0] wait_a;
  logic [STAT_WIDTH-1:0] wait_b;
  logic [STAT_WIDTH-1:0] grant_wait;

  assign done_a  = (state == BUSY_A) && mem_ready;
  assign done_b  = (state == BUSY_B) && mem_ready;
  assign a_ready = done_a;
  assign b_ready = done_b;
  assign a_rdata = done_a ? mem_rdata : '0;
  assign b_rdata = done_b ? mem_rdata : '0;

  // A completing requester is never re-granted in its own ready cycle; only the other side may follow.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    case (state)
      IDLE: begin
        if (a_valid && b_valid) begin
          if (b_priority || !last_grant_b) grant_b = 1'b1;
          else                             grant_a = 1'b1;
        end else if (a_valid) begin
          grant_a = 1'b1;
        end else if (b_valid) begin
          grant_b = 1'b1;
        end
      end
      BUSY_A:  grant_b = mem_ready && b_valid;
      BUSY_B:  grant_a = mem_ready && a_valid;
      default: ;
    endcase
  end

  assign grant_wait = grant_a ? wait_a : wait_b;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      mem_valid    <= 1'b0;
      mem_addr     <= '0;
      last_grant_b <= 1'b1;
    end else begin
      if (grant_a) begin
        state     <= BUSY_A;
        mem_valid <= 1'b1;
        mem_addr  <= a_addr;
      end else if (grant_b) begin
        state     <= BUSY_B;
        mem_valid <= 1'b1;
        mem_addr  <= b_addr;
      end else if (done_a || done_b) begin
        state     <= IDLE;
        mem_valid <= 1'b0;
      end
      if (done_a) last_grant_b <= 1'b0;
      if (done_b) last_grant_b <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_a <= '0;
      wait_b <= '0;
    end else begin
      if (grant_a)
        wait_a <= '0;
      else if (a_valid && state != BUSY_A && wait_a != STAT_MAX)
        wait_a <= wait_a + 1'b1;
      if (grant_b)
        wait_b <= '0;
      else if (b_valid && state != BUSY_B && wait_b != STAT_MAX)
        wait_b <= wait_b + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_grant_count <= '0;
      b_grant_count <= '0;
      max_wait      <= '0;
    end else if (stat_clear) begin
      a_grant_count <= '0;
      b_grant_count <= '0;
      max_wait      <= '0;
    end else begin
      if (done_a && a_grant_count != STAT_MAX) a_grant_count <= a_grant_count + 1'b1;
      if (done_b && b_grant_count != STAT_MAX) b_grant_count <= b_grant_count + 1'b1;
      if ((grant_a || grant_b) && grant_wait > max_wait) max_wait <= grant_wait;
    end
  end

endmodule
